// File: rtl/nn0_axil_pkg.sv
// nn0_axil_pkg: AXI4-Lite response codes, write/read FSM encodings and the word-index helper
// shared by nn0_axil_regbank and nn0_axil_wr_collect. No ports; no latency.
// Optional decode-error responses are selected in the top by NN0_AXIL_SLVERR_EN.
package nn0_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write FSM: collecting AW/W, then waiting for the B handshake.
    localparam logic [0:0] W_COLLECT = 1'b0;
    localparam logic [0:0] W_RESP    = 1'b1;

    // Read FSM: accepting AR, then holding R until accepted.
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_DATA    = 1'b1;

    // Byte address (zero-extended to 32 bits) to 32-bit word index.
    function automatic logic [29:0] word_idx(input logic [31:0] byte_addr);
        return 30'(byte_addr >> 2);
    endfunction

endpackage

// File: rtl/nn0_axil_wr_collect.sv
// nn0_axil_wr_collect: captures AW and W independently (either order or same cycle) into holding flops.
// Latency: a beat is held one edge after its handshake; both_held_o is high from then until clear_i.
// Backpressure: awready_o/wready_o are the inverse of the held flags, so each channel stalls once captured.
// Ports: clk_i/rst_i (sync, active-high); AW and W channel inputs with their readies;
//        clear_i releases both holds; both_held_o plus the held address/data/strobe feed the commit.
module nn0_axil_wr_collect
    import nn0_axil_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] awaddr_i,
    input  logic              awvalid_i,
    output logic              awready_o,
    input  logic [31:0]       wdata_i,
    input  logic [3:0]        wstrb_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic              clear_i,
    output logic              both_held_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       data_o,
    output logic [3:0]        strb_o
);

    logic              aw_held_q, aw_held_d;
    logic              w_held_q,  w_held_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [31:0]       data_q,    data_d;
    logic [3:0]        strb_q,    strb_d;

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (clear_i) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (awvalid_i && !aw_held_q) begin
                aw_held_d = 1'b1;
                addr_d    = awaddr_i;
            end
            if (wvalid_i && !w_held_q) begin
                w_held_d = 1'b1;
                data_d   = wdata_i;
                strb_d   = wstrb_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
        end
    end

    // Readies come straight from flops: no VALID-to-READY combinational path.
    // The holds stay set through the response phase, which also keeps both readies low there.
    assign awready_o   = !aw_held_q;
    assign wready_o    = !w_held_q;
    assign both_held_o = aw_held_q && w_held_q;
    assign addr_o      = addr_q;
    assign data_o      = data_q;
    assign strb_o      = strb_q;

endmodule

// File: rtl/nn0_axil_regbank.sv
// nn0_axil_regbank: AXI4-Lite slave with NUM_REGS 32-bit control registers, one outstanding op per direction.
// Latency: commit + BVALID one edge after both AW and W are held; RVALID one edge after the AR handshake.
// Backpressure: BVALID/RVALID (and RDATA/RESP) held until BREADY/RREADY; AW/W/AR stall while a response is pending.
// Ports: ACLK/ARESET (sync, active-high); full S_AXI AW/W/B/AR/R channels (PROT ignored);
//        reg_out = flat register contents (reg i at [32*i+31:32*i]); reg_wr_pulse = 1-cycle commit strobe per reg.
// Optional macro NN0_AXIL_SLVERR_EN: unimplemented indices answer SLVERR instead of OKAY.
module nn0_axil_regbank
    import nn0_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_REGS*32-1:0]          reg_out,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    logic [0:0]                    w_state_q, w_state_d;
    logic [0:0]                    r_state_q, r_state_d;
    logic [31:0]                   regs_q [NUM_REGS];
    logic [31:0]                   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]           pulse_q, pulse_d;
    logic                          bvalid_q, bvalid_d;
    logic [1:0]                    bresp_q, bresp_d;
    logic                          rvalid_q, rvalid_d;
    logic [1:0]                    rresp_q, rresp_d;
    logic [31:0]                   rdata_q, rdata_d;

    logic                          both_held;
    logic                          wr_clear;
    logic [C_S_AXI_ADDR_WIDTH-1:0] held_addr;
    logic [31:0]                   held_data;
    logic [3:0]                    held_strb;
    logic [29:0]                   wr_idx, rd_idx;
    logic [31:0]                   rd_word;
    logic [1:0]                    wr_resp, rd_resp;
    logic                          unused_prot;

    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Holds are released on the B handshake, reopening AW/W for the next write.
    assign wr_clear = (w_state_q == W_RESP) && S_AXI_BREADY;

    nn0_axil_wr_collect #(
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_wr_collect (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .awaddr_i    (S_AXI_AWADDR),
        .awvalid_i   (S_AXI_AWVALID),
        .awready_o   (S_AXI_AWREADY),
        .wdata_i     (S_AXI_WDATA),
        .wstrb_i     (S_AXI_WSTRB),
        .wvalid_i    (S_AXI_WVALID),
        .wready_o    (S_AXI_WREADY),
        .clear_i     (wr_clear),
        .both_held_o (both_held),
        .addr_o      (held_addr),
        .data_o      (held_data),
        .strb_o      (held_strb)
    );

    assign wr_idx = word_idx(32'(held_addr));
    assign rd_idx = word_idx(32'(S_AXI_ARADDR));

`ifdef NN0_AXIL_SLVERR_EN
    logic wr_hit, rd_hit;
    assign wr_hit  = (wr_idx < 30'(NUM_REGS));
    assign rd_hit  = (rd_idx < 30'(NUM_REGS));
    assign wr_resp = wr_hit ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = rd_hit ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    // Out-of-range indices match no entry and therefore read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 30'(i)) rd_word = regs_q[i];
        end
    end

    // Write path: the commit is gated by W_COLLECT because the holds stay set during W_RESP.
    always_comb begin
        w_state_d = w_state_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        pulse_d   = '0;
        regs_d    = regs_q;
        case (w_state_q)
            W_COLLECT: begin
                if (both_held) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_idx == 30'(i)) begin
                            pulse_d[i] = 1'b1;
                            for (int b = 0; b < 4; b++) begin
                                if (held_strb[b]) regs_d[i][8*b +: 8] = held_data[8*b +: 8];
                            end
                        end
                    end
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_resp;
                    w_state_d = W_RESP;
                end
            end
            default: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_COLLECT;
                end
            end
        endcase
    end

    // Read path: rd_word is taken from the current flops, so a same-edge commit is not visible yet.
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    rdata_d   = rd_word;
                    rresp_d   = rd_resp;
                    rvalid_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            default: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_COLLECT;
            r_state_q <= R_IDLE;
            pulse_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            pulse_q   <= pulse_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign S_AXI_ARREADY = (r_state_q == R_IDLE);
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign reg_wr_pulse  = pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_nn0_axil_regbank.sv
module tb_nn0_axil_regbank;

    localparam int AW = 5;
    localparam int NR = 4;
`ifdef NN0_AXIL_SLVERR_EN
    localparam logic [1:0] ERR_RESP = 2'b10;
`else
    localparam logic [1:0] ERR_RESP = 2'b00;
`endif

    logic            aclk = 1'b0;
    logic            areset;
    logic [AW-1:0]   s_axi_awaddr;
    logic [2:0]      s_axi_awprot;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [31:0]     s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [AW-1:0]   s_axi_araddr;
    logic [2:0]      s_axi_arprot;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]   reg_wr_pulse;

    always #5 aclk = ~aclk;

    nn0_axil_regbank #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .NUM_REGS           (NR)
    ) dut (
        .ACLK          (aclk),
        .ARESET        (areset),
        .S_AXI_AWADDR  (s_axi_awaddr),
        .S_AXI_AWPROT  (s_axi_awprot),
        .S_AXI_AWVALID (s_axi_awvalid),
        .S_AXI_AWREADY (s_axi_awready),
        .S_AXI_WDATA   (s_axi_wdata),
        .S_AXI_WSTRB   (s_axi_wstrb),
        .S_AXI_WVALID  (s_axi_wvalid),
        .S_AXI_WREADY  (s_axi_wready),
        .S_AXI_BRESP   (s_axi_bresp),
        .S_AXI_BVALID  (s_axi_bvalid),
        .S_AXI_BREADY  (s_axi_bready),
        .S_AXI_ARADDR  (s_axi_araddr),
        .S_AXI_ARPROT  (s_axi_arprot),
        .S_AXI_ARVALID (s_axi_arvalid),
        .S_AXI_ARREADY (s_axi_arready),
        .S_AXI_RDATA   (s_axi_rdata),
        .S_AXI_RRESP   (s_axi_rresp),
        .S_AXI_RVALID  (s_axi_rvalid),
        .S_AXI_RREADY  (s_axi_rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents and expected commit-pulse counts per register.
    logic [31:0] model     [NR];
    int          exp_pulse [NR];
    int          pulse_cnt [NR];

    always @(negedge aclk) begin
        for (int i = 0; i < NR; i++) begin
            if (reg_wr_pulse[i] === 1'b1) pulse_cnt[i] = pulse_cnt[i] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'((addr % 32) / 4);
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int k;
        k = idx_of(addr);
        if (k >= NR) return ERR_RESP;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[k][8*b +: 8] = data[8*b +: 8];
        end
        exp_pulse[k]++;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        int k;
        k = idx_of(addr);
        return (k < NR) ? model[k] : 32'h0;
    endfunction

    function automatic logic [1:0] model_rresp(input logic [31:0] addr);
        return (idx_of(addr) < NR) ? 2'b00 : ERR_RESP;
    endfunction

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        int   cyc;
        bit   aw_done, w_done, stable;
        logic aw_hs, w_hs;
        cyc = 0; aw_done = 0; w_done = 0; stable = 1;
        s_axi_awaddr = addr[AW-1:0];
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
        end
        s_axi_awvalid = 0;
        s_axi_wvalid  = 0;
        check("wr_aw_w_handshake", 128'(aw_done && w_done), 128'(1));
        cyc = 0;
        while (!s_axi_bvalid && cyc < 40) begin
            @(posedge aclk); #1;
            cyc++;
        end
        check("wr_bvalid_seen", 128'(s_axi_bvalid), 128'(1));
        resp = s_axi_bresp;
        repeat (b_dly) begin
            @(posedge aclk); #1;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== resp) stable = 0;
        end
        check("wr_b_hold", 128'(stable), 128'(1));
        s_axi_bready = 1;
        @(posedge aclk); #1;
        s_axi_bready = 0;
        check("wr_b_cleared", 128'(s_axi_bvalid), 128'(0));
    endtask

    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly,
                            output logic [31:0] data, output logic [1:0] resp);
        int   cyc;
        bit   done, stable;
        logic hs;
        cyc = 0; done = 0; stable = 1;
        s_axi_araddr = addr[AW-1:0];
        while (!done && cyc < 40) begin
            s_axi_arvalid = (cyc >= ar_dly);
            hs = s_axi_arvalid && s_axi_arready;
            @(posedge aclk); #1;
            cyc++;
            if (hs) done = 1;
        end
        s_axi_arvalid = 0;
        check("rd_ar_handshake", 128'(done), 128'(1));
        cyc = 0;
        while (!s_axi_rvalid && cyc < 40) begin
            @(posedge aclk); #1;
            cyc++;
        end
        check("rd_rvalid_seen", 128'(s_axi_rvalid), 128'(1));
        data = s_axi_rdata;
        resp = s_axi_rresp;
        repeat (r_dly) begin
            @(posedge aclk); #1;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== data || s_axi_rresp !== resp) stable = 0;
        end
        check("rd_r_hold", 128'(stable), 128'(1));
        s_axi_rready = 1;
        @(posedge aclk); #1;
        s_axi_rready = 0;
        check("rd_r_cleared", 128'(s_axi_rvalid), 128'(0));
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
    } vec_t;

    initial begin
        vec_t        vecs [8];
        logic [31:0] rd, addr, data;
        logic [1:0]  resp, exp_r;
        logic [3:0]  strb;
        bit          stable;

        vecs[0] = '{32'h00, 32'h0101FFFF, 4'hF, 32'h0101FFFF, 2'b00};
        vecs[1] = '{32'h04, 32'hABCD0001, 4'hF, 32'hABCD0001, 2'b00};
        vecs[2] = '{32'h08, 32'hDEAD0011, 4'hF, 32'hDEAD0011, 2'b00};
        vecs[3] = '{32'h0C, 32'hBEEF0011, 4'hF, 32'hBEEF0011, 2'b00};
        vecs[4] = '{32'h00, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF, 2'b00};
        vecs[5] = '{32'h00, 32'h00000000, 4'h5, 32'hFF00FF00, 2'b00};
        vecs[6] = '{32'h14, 32'h00000055, 4'hF, 32'h00000000, ERR_RESP};
        vecs[7] = '{32'h10, 32'hFFFFFFFF, 4'hF, 32'h00000000, ERR_RESP};

        for (int i = 0; i < NR; i++) begin
            model[i] = '0; exp_pulse[i] = 0; pulse_cnt[i] = 0;
        end
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 0; s_axi_bready = 0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 0; s_axi_rready = 0;

        areset = 1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 0;
        check("rst_readies", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'(3'b111));
        check("rst_valids", 128'({s_axi_bvalid, s_axi_rvalid}), 128'(2'b00));
        check("rst_resps", 128'({s_axi_bresp, s_axi_rresp}), 128'(4'b0000));
        check("rst_rdata", 128'(s_axi_rdata), 128'(0));
        check("rst_reg_out", reg_out, 128'(0));
        check("rst_pulse", 128'(reg_wr_pulse), 128'(0));

        // Directed write/readback table.
        for (int i = 0; i < 8; i++) begin
            void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp);
            check($sformatf("vec%0d_bresp", i), 128'(resp), 128'(vecs[i].exp_resp));
            axi_read(vecs[i].addr, 0, 0, rd, resp);
            check($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vecs[i].exp_rd));
            check($sformatf("vec%0d_rresp", i), 128'(resp), 128'(vecs[i].exp_resp));
            if (i == 3) begin
                check("t1_reg_out", reg_out, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});
                for (int k = 0; k < NR; k++) check($sformatf("t1_pulse%0d", k), 128'(pulse_cnt[k]), 128'(1));
            end
        end
        for (int k = 0; k < NR; k++) check($sformatf("tbl_pulse%0d", k), 128'(pulse_cnt[k]), 128'(exp_pulse[k]));

        // W three cycles ahead of AW; commit one edge after the AW handshake.
        s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1;
        @(posedge aclk); #1;
        s_axi_wvalid = 0;
        check("t2_wready_drop", 128'(s_axi_wready), 128'(0));
        repeat (2) begin @(posedge aclk); #1; end
        check("t2_no_early_b", 128'(s_axi_bvalid), 128'(0));
        s_axi_awaddr = 5'h04; s_axi_awvalid = 1;
        @(posedge aclk); #1;
        s_axi_awvalid = 0;
        check("t2_b_not_yet", 128'(s_axi_bvalid), 128'(0));
        @(posedge aclk); #1;
        check("t2_bvalid", 128'({s_axi_bvalid, s_axi_bresp}), 128'(3'b100));
        check("t2_reg1", 128'(reg_out[63:32]), 128'(32'h12345678));
        check("t2_pulse", 128'(reg_wr_pulse), 128'(4'b0010));
        void'(model_write(32'h04, 32'h12345678, 4'hF));
        s_axi_bready = 1;
        @(posedge aclk); #1;
        s_axi_bready = 0;

        // Same-edge AR and commit to reg2: read returns the old value.
        s_axi_awaddr = 5'h08; s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        @(posedge aclk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 5'h08; s_axi_arvalid = 1;
        @(posedge aclk); #1;
        s_axi_arvalid = 0;
        check("t5_rvalid_bvalid", 128'({s_axi_rvalid, s_axi_bvalid}), 128'(2'b11));
        check("t5_old_rdata", 128'(s_axi_rdata), 128'(32'hDEAD0011));
        check("t5_reg2_new", 128'(reg_out[95:64]), 128'(0));
        void'(model_write(32'h08, 32'h0, 4'hF));
        s_axi_bready = 1; s_axi_rready = 1;
        @(posedge aclk); #1;
        s_axi_bready = 0; s_axi_rready = 0;
        axi_read(32'h08, 0, 0, rd, resp);
        check("t5_new_rdata", 128'(rd), 128'(0));

        // Responses stalled for 5 cycles while new AW/W/AR are offered.
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h13579BDF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        s_axi_araddr = 5'h04; s_axi_arvalid = 1;
        @(posedge aclk); #1;
        void'(model_write(32'h0C, 32'h13579BDF, 4'hF));
        s_axi_awaddr = 5'h00; s_axi_wdata = 32'hFFFFFFFF; s_axi_araddr = 5'h00;
        @(posedge aclk); #1;
        stable = 1;
        repeat (5) begin
            if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || s_axi_rdata !== model[1] ||
                s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0 || s_axi_arready !== 1'b0) stable = 0;
            @(posedge aclk); #1;
        end
        check("t4_stall_stable", 128'(stable), 128'(1));
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        check("t4_rdata", 128'(s_axi_rdata), 128'(32'h12345678));
        check("t4_reg_out", reg_out, model_flat());
        s_axi_bready = 1; s_axi_rready = 1;
        @(posedge aclk); #1;
        s_axi_bready = 0; s_axi_rready = 0;
        check("t4_released", 128'({s_axi_bvalid, s_axi_rvalid, s_axi_awready, s_axi_arready}), 128'(4'b0011));

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            addr = $urandom_range(0, 7) * 4;
            if ($urandom_range(0, 1) == 1) begin
                data  = $urandom;
                strb  = 4'($urandom_range(0, 15));
                exp_r = model_write(addr, data, strb);
                axi_write(addr, data, strb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), resp);
                check($sformatf("rnd%0d_bresp", n), 128'(resp), 128'(exp_r));
            end else begin
                axi_read(addr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rd, resp);
                check($sformatf("rnd%0d_rdata", n), 128'(rd), 128'(model_read(addr)));
                check($sformatf("rnd%0d_rresp", n), 128'(resp), 128'(model_rresp(addr)));
            end
        end
        check("rnd_reg_out", reg_out, model_flat());
        for (int k = 0; k < NR; k++) check($sformatf("rnd_pulse%0d", k), 128'(pulse_cnt[k]), 128'(exp_pulse[k]));

        // Reset while BVALID and RVALID are pending.
        s_axi_awaddr = 5'h04; s_axi_wdata = 32'h0BADBEEF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_araddr = 5'h00; s_axi_arvalid = 1;
        @(posedge aclk); #1;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        void'(model_write(32'h04, 32'h0BADBEEF, 4'hF));
        @(posedge aclk); #1;
        check("t6_pre_valids", 128'({s_axi_bvalid, s_axi_rvalid}), 128'(2'b11));
        areset = 1;
        @(posedge aclk); #1;
        areset = 0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        check("t6_reg_out", reg_out, 128'(0));
        check("t6_valids", 128'({s_axi_bvalid, s_axi_rvalid}), 128'(2'b00));
        check("t6_readies", 128'({s_axi_awready, s_axi_wready, s_axi_arready}), 128'(3'b111));
        check("t6_rdata", 128'(s_axi_rdata), 128'(0));

        // Reset with only AW held: the stale address must not pair with the next W.
        s_axi_awaddr = 5'h08; s_axi_awvalid = 1;
        @(posedge aclk); #1;
        s_axi_awvalid = 0;
        check("t6_aw_held", 128'(s_axi_awready), 128'(0));
        areset = 1;
        @(posedge aclk); #1;
        areset = 0;
        check("t6_aw_released", 128'(s_axi_awready), 128'(1));
        void'(model_write(32'h0C, 32'hCAFEF00D, 4'hF));
        axi_write(32'h0C, 32'hCAFEF00D, 4'hF, 4, 0, 0, resp);
        check("t6_post_reg_out", reg_out, model_flat());
        for (int k = 0; k < NR; k++) check($sformatf("end_pulse%0d", k), 128'(pulse_cnt[k]), 128'(exp_pulse[k]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nn0_axil_regbank.md
Name: nn0_axil_regbank

Overview:
AXI4-Lite slave register bank: the responder end of the S00_AXI port driven by the nn0 master BFM.
- Accepts single-beat writes and reads into NUM_REGS 32-bit control registers.
- Exposes register contents and per-register write strobes to the nn0 compute core.
- Sits between the AXI interconnect and the nn0 datapath.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 4, byte-address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2].
NUM_REGS, 4, number of implemented registers; must be <= 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
ACLK  in  1  single clock; all logic on rising edge
ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
reg_out  out  NUM_REGS*32  flat register contents; reg i at [32*i+31:32*i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after a commit to reg i

Behaviour:
- Reset (ARESET=1 at a clock edge):
  - All registers = 0; reg_wr_pulse = 0.
  - AWREADY, WREADY and ARREADY = 1.
  - BVALID and RVALID = 0; BRESP and RRESP = 00; RDATA = 0.
  - Any in-flight transaction is abandoned, including one asserted mid-handshake.
- Write FSM states: W_COLLECT, W_RESP.
  - W_COLLECT: AW and W are captured independently into holding flops aw_held / w_held, in either order or in the same cycle.
  - AWREADY = !aw_held; WREADY = !w_held.
  - When both are held, the commit happens on the next edge:
    - Bytes updated per WSTRB; strobe-0 bytes retain their value.
    - reg_wr_pulse[idx] asserted for exactly 1 cycle.
    - BVALID = 1, BRESP = OKAY; go to W_RESP.
  - Minimum latency: AW+W in the same cycle at edge N, commit and BVALID at edge N+1.
  - W_RESP: AWREADY = WREADY = 0. BVALID is held until BREADY; then go to W_COLLECT with the holding flops cleared.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY = 1. On ARVALID, RDATA is loaded from the addressed register and RVALID = 1 at the next edge; go to R_DATA with ARREADY = 0.
  - R_DATA: RDATA, RRESP and RVALID are held stable until RREADY; then return to R_IDLE.
- Simultaneous read and commit to the same register: the read returns the pre-write value; the write still lands.
- Unimplemented index (idx >= NUM_REGS), without the optional feature:
  - Writes are dropped with no pulse; BRESP = OKAY.
  - Reads return 0 with RRESP = OKAY.
- Read and write channels operate fully concurrently; one outstanding transaction per direction.
- BVALID/RVALID never drop without the matching READY; no combinational path from any VALID input to any READY output.

Optional Feature:
- Macro: NN0_AXIL_SLVERR_EN.
- Defined: accesses to idx >= NUM_REGS return BRESP/RRESP = 2'b10 (SLVERR). Reads still return RDATA = 0; writes are still dropped.
- Undefined: OKAY is returned as in Behaviour; no decode-error logic is synthesised.

Decomposition:
- Shared package nn0_axil_pkg:
  - RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10.
  - State encodings for the W and R FSMs.
  - Word-index extraction helper.
- One natural sub-module: nn0_axil_wr_collect, the AW/W independent-capture holding logic with its ready generation.

Test Plan:
1. Reset, then four sequential write/readback pairs (WSTRB = 4'hF) at offsets 0x0, 0x4, 0x8, 0xC with 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 -> each BRESP and RRESP = 00; reads match; reg_out holds all four; each reg_wr_pulse bit fires once.
2. W presented 3 cycles before AW at offset 0x4 with data 0x12345678 -> WREADY drops after capture; commit 1 cycle after the AW handshake; reg1 = 0x12345678.
3. Register at 0x0 preset to 0xFFFFFFFF; write 0x00000000 with WSTRB = 4'b0101 -> read back 0xFF00FF00.
4. BREADY and RREADY held low for 5 cycles -> BVALID/RVALID and RDATA stable throughout; no new AW or AR accepted.
5. Same-edge AR and write commit to offset 0x8 (old 0xdead0011, new 0x0) -> RDATA = 0xdead0011; subsequent read = 0x0.
6. ARESET asserted while BVALID = 1 and aw_held is set -> next cycle all registers 0, BVALID = 0, READYs = 1. Also a read at offset 0x10 with C_S_AXI_ADDR_WIDTH = 5 -> RDATA = 0, RRESP = 00, or 10 with NN0_AXIL_SLVERR_EN.
